sram_responder: RTL and testbench
=================================

// Module: sram_responder
// PURPOSE
//  Memory-side responder for the MEM-stage data port: accepts 32-bit word read/write requests
//  (clk, address, wr_data, wr_en, rd_en) and services them on an external 16-bit SRAM
//  with configurable wait states. Drives ready low while busy so the pipeline freezes;
//  rd_data holds the last completed read.
// PARAMETERS
//  BASE_ADDR  1024  byte address mapped to SRAM word 0
//  SRAM_AW    18    external SRAM address width (16-bit half-word granularity)
//  WAIT_CYC   2     cycles each SRAM half-access is held (>=1)
// PORTS
//  clk         in   1        single clock, rising edge
//  rst         in   1        synchronous, active-high reset
//  wr_en       in   1        write request; held until ready=1
//  rd_en       in   1        read request; held until ready=1
//  address     in   32       byte address, word aligned (bits[1:0] ignored)
//  wr_data     in   32       write word
//  rd_data     out  32       last completed read word
//  ready       out  1        1 = no pending work or request completes this cycle
//  sram_addr   out  SRAM_AW  SRAM half-word address
//  sram_dq_o   out  16       SRAM write data
//  sram_dq_oe  out  1        1 = drive sram_dq_o onto the SRAM bus
//  sram_dq_i   in   16       SRAM read data
//  sram_we_n   out  1        SRAM write strobe, active low
// BEHAVIOUR
//  - Reset: state IDLE, rd_data=0, sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_o=0, wait count=0.
//  - Word index w = ((address - BASE_ADDR) mod 2^32) >> 2; low half at {w,0}, high half at {w,1},
//    both truncated to SRAM_AW bits; out-of-range addresses wrap silently.
//  - FSM: IDLE -> (WR_LO->WR_HI | RD_LO->RD_HI) -> DONE -> IDLE.
//    IDLE: on wr_en (priority) or rd_en, latch address/wr_data/op; go to *_LO.
//    *_LO, *_HI: each lasts exactly WAIT_CYC cycles (counter reloads on entry).
//    DONE: exactly 1 cycle, then IDLE unconditionally.
//  - Write phases: sram_addr=half addr, sram_dq_o=latched half, sram_dq_oe=1, sram_we_n=0 for all
//    WAIT_CYC cycles; outside write phases sram_we_n=1, sram_dq_oe=0.
//  - Read phases: sram_addr=half addr; sram_dq_i sampled on last cycle of RD_LO (low half) and
//    RD_HI (high half); rd_data updated as full word on entry to DONE, else held.
//  - ready (combinational) = (state==IDLE & ~wr_en & ~rd_en) | (state==DONE).
//  - Latency: request first seen in IDLE at cycle 0 -> ready=1 at cycle 2*WAIT_CYC+1.
//  - Back-to-back: new request presented in the cycle after DONE is accepted from IDLE;
//    throughput one word per 2*WAIT_CYC+2 cycles.
//  - wr_en & rd_en together: treated as write; read not performed.
//  - Request deasserted mid-operation: transaction completes on latched values; ready stays 0
//    until DONE. Inputs changing mid-operation are ignored.
//  - rst mid-operation: FSM to IDLE next edge, strobes deasserted, SRAM write may be partial.
// STRUCTURE
//  - Package sram_pkg: state enum (IDLE, WR_LO, WR_HI, RD_LO, RD_HI, DONE), BASE_ADDR default,
//    SRAM data width 16, word width 32.
//  - One sub-module: wait_counter (load WAIT_CYC on phase entry, 'last' flag at count 1).
//  - Top holds FSM, request latch, address computation, read-assembly register.
// TESTING (WAIT_CYC=2, behavioural 16-bit SRAM model)
//  - Write 0xDEADBEEF @1024 -> SRAM[0]=0xBEEF, SRAM[1]=0xDEAD; we_n low 2+2 cycles; ready=1 at cycle 5.
//  - Read @1024 after above -> rd_data=0xDEADBEEF at cycle 5 (ready=1); held through later writes.
//  - Write 0x12345678 @1032 then immediately read @1032 -> SRAM[4]/[5]=0x5678/0x1234; read returns 0x12345678.
//  - wr_en=rd_en=1, address 1028, wr_data 0xA5A5A5A5 -> SRAM[2]/[3] written; rd_data unchanged.
//  - rst asserted in WR_HI -> next cycle state IDLE, we_n=1, dq_oe=0, ready=1 (no request); rd_data=0.
//  - Idle with no request -> ready=1, we_n=1, dq_oe=0 continuously; SRAM model sees no writes.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM responder.
package sram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_LO,
        WR_HI,
        RD_LO,
        RD_HI,
        DONE
    } state_t;

    localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;
    localparam int unsigned SRAM_DW       = 16;
    localparam int unsigned WORD_W        = 32;

endpackage

// File: rtl/wait_counter.sv
// Wait-state counter: reloads to WAIT_CYC on phase entry, flags the final cycle of a phase.
module wait_counter
    import sram_pkg::*;
#(
    parameter int unsigned WAIT_CYC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic last
);

    localparam int unsigned CW = $clog2(WAIT_CYC + 1);

    logic [CW-1:0] count_q, count_d;

    // Next count: reload on phase entry, otherwise count down to zero
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = CW'(WAIT_CYC);
        end else if (count_q != '0) begin
            count_d = count_q - CW'(1);
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last = (count_q == CW'(1));

endmodule

// File: rtl/sram_responder.sv
// Memory-side responder: 32-bit word requests serviced as two 16-bit SRAM half-accesses.
module sram_responder
    import sram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
    parameter int unsigned SRAM_AW   = 18,
    parameter int unsigned WAIT_CYC  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        wr_data,
    output logic [31:0]        rd_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_o,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_i,
    output logic               sram_we_n
);

    localparam int unsigned WAW = SRAM_AW - 1;

    state_t               state_q, state_d;
    logic [WAW-1:0]       word_q, word_d;
    logic [SRAM_DW-1:0]   wr_hi_q, wr_hi_d;
    logic [SRAM_DW-1:0]   rd_lo_q, rd_lo_d;
    logic [WORD_W-1:0]    rd_data_q, rd_data_d;
    logic [SRAM_AW-1:0]   sram_addr_q, sram_addr_d;
    logic [SRAM_DW-1:0]   dq_o_q, dq_o_d;
    logic                 dq_oe_q, dq_oe_d;
    logic                 we_n_q, we_n_d;
    logic                 load;
    logic                 last;
    logic [31:0]          offset;
    logic [WAW-1:0]       req_word;
    logic                 addr_lsb_unused;

    // Word index relative to the base; upper bits beyond the SRAM are dropped (silent wrap)
    assign offset          = address - BASE_ADDR;
    assign req_word        = WAW'(offset[31:2]);
    assign addr_lsb_unused = ^offset[1:0];

    wait_counter #(
        .WAIT_CYC(WAIT_CYC)
    ) u_wait (
        .clk (clk),
        .rst (rst),
        .load(load),
        .last(last)
    );

    // Next-state, request latch, read assembly and next SRAM strobes (outputs are registered)
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        wr_hi_d     = wr_hi_q;
        rd_lo_d     = rd_lo_q;
        rd_data_d   = rd_data_q;
        sram_addr_d = sram_addr_q;
        dq_o_d      = dq_o_q;
        dq_oe_d     = dq_oe_q;
        we_n_d      = we_n_q;
        load        = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_en) begin
                    state_d     = WR_LO;
                    word_d      = req_word;
                    wr_hi_d     = wr_data[WORD_W-1:SRAM_DW];
                    sram_addr_d = {req_word, 1'b0};
                    dq_o_d      = wr_data[SRAM_DW-1:0];
                    dq_oe_d     = 1'b1;
                    we_n_d      = 1'b0;
                    load        = 1'b1;
                end else if (rd_en) begin
                    state_d     = RD_LO;
                    word_d      = req_word;
                    sram_addr_d = {req_word, 1'b0};
                    load        = 1'b1;
                end
            end
            WR_LO: begin
                if (last) begin
                    state_d     = WR_HI;
                    sram_addr_d = {word_q, 1'b1};
                    dq_o_d      = wr_hi_q;
                    load        = 1'b1;
                end
            end
            WR_HI: begin
                if (last) begin
                    state_d = DONE;
                    dq_oe_d = 1'b0;
                    we_n_d  = 1'b1;
                end
            end
            RD_LO: begin
                if (last) begin
                    state_d     = RD_HI;
                    rd_lo_d     = sram_dq_i;
                    sram_addr_d = {word_q, 1'b1};
                    load        = 1'b1;
                end
            end
            RD_HI: begin
                if (last) begin
                    state_d   = DONE;
                    rd_data_d = {sram_dq_i, rd_lo_q};
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            word_q      <= '0;
            wr_hi_q     <= '0;
            rd_lo_q     <= '0;
            rd_data_q   <= '0;
            sram_addr_q <= '0;
            dq_o_q      <= '0;
            dq_oe_q     <= 1'b0;
            we_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            wr_hi_q     <= wr_hi_d;
            rd_lo_q     <= rd_lo_d;
            rd_data_q   <= rd_data_d;
            sram_addr_q <= sram_addr_d;
            dq_o_q      <= dq_o_d;
            dq_oe_q     <= dq_oe_d;
            we_n_q      <= we_n_d;
        end
    end

    assign ready      = ((state_q == IDLE) && !wr_en && !rd_en) || (state_q == DONE);
    assign rd_data    = rd_data_q;
    assign sram_addr  = sram_addr_q;
    assign sram_dq_o  = dq_o_q;
    assign sram_dq_oe = dq_oe_q;
    assign sram_we_n  = we_n_q;

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder with a behavioural 16-bit SRAM.
module tb_sram_responder;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_o;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_i;
    logic        sram_we_n;

    int unsigned checks = 0;
    int unsigned errors = 0;

    sram_responder #(
        .BASE_ADDR(32'd1024),
        .SRAM_AW  (18),
        .WAIT_CYC (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .address   (address),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .ready     (ready),
        .sram_addr (sram_addr),
        .sram_dq_o (sram_dq_o),
        .sram_dq_oe(sram_dq_oe),
        .sram_dq_i (sram_dq_i),
        .sram_we_n (sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural asynchronous SRAM
    logic [15:0] sram [0:262143];
    int unsigned sram_writes = 0;
    assign sram_dq_i = sram[sram_addr];
    always @(posedge clk) begin
        if (!sram_we_n) begin
            sram[sram_addr] <= sram_dq_o;
            sram_writes     <= sram_writes + 1;
        end
    end

    // Reference model: half-word store keyed by SRAM address, plus last completed read
    logic [15:0] ref_mem [int unsigned];
    logic [31:0] ref_last_rd = 32'h0;

    function automatic int unsigned half_of(input logic [31:0] a, input bit hi);
        longint unsigned w;
        w = longint'((a - 32'd1024) / 32'd4);
        return int'((w * 2 + longint'(hi)) % 262144);
    endfunction

    function automatic logic [15:0] ref_rd(input int unsigned h);
        if (ref_mem.exists(h)) return ref_mem[h];
        return 16'h0;
    endfunction

    task automatic model_apply(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
        if (wr) begin
            ref_mem[half_of(a, 1'b0)] = d[15:0];
            ref_mem[half_of(a, 1'b1)] = d[31:16];
        end else if (rd) begin
            ref_last_rd = {ref_rd(half_of(a, 1'b1)), ref_rd(half_of(a, 1'b0))};
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One transaction, entered just after a rising edge. Latency counts cycles from the
    // request cycle to the cycle where ready returns; drop_at removes the request mid-flight.
    task automatic xact(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d,
                        input int drop_at, output int lat, output int wen_low);
        wr_en   = wr;
        rd_en   = rd;
        address = a;
        wr_data = d;
        lat     = -1;
        wen_low = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!sram_we_n) wen_low++;
            if (ready) begin
                lat = c;
                break;
            end
            if (c == drop_at) begin
                wr_en   = 1'b0;
                rd_en   = 1'b0;
                address = 32'hFFFF_FFFF;
                wr_data = 32'h0;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        model_apply(wr, rd, a, d);
    endtask

    typedef struct {
        bit          wr;
        bit          rd;
        logic [31:0] addr;
        logic [31:0] data;
        int          drop_at;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int          lat;
        int          wl;
        int unsigned w0;
        vec_t        v;

        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        address = 32'h0;
        wr_data = 32'h0;

        vecs.push_back('{1'b1, 1'b0, 32'd1024,   32'hDEADBEEF, 99, 32'h00000000});
        vecs.push_back('{1'b0, 1'b1, 32'd1024,   32'h0,        99, 32'hDEADBEEF});
        vecs.push_back('{1'b1, 1'b0, 32'd1032,   32'h12345678, 99, 32'hDEADBEEF});
        vecs.push_back('{1'b0, 1'b1, 32'd1032,   32'h0,        99, 32'h12345678});
        vecs.push_back('{1'b1, 1'b1, 32'd1028,   32'hA5A5A5A5, 99, 32'h12345678});
        vecs.push_back('{1'b0, 1'b1, 32'd1028,   32'h0,        2,  32'hA5A5A5A5});
        vecs.push_back('{1'b1, 1'b0, 32'd1020,   32'hCAFEF00D, 1,  32'hA5A5A5A5});
        vecs.push_back('{1'b0, 1'b1, 32'd1020,   32'h0,        99, 32'hCAFEF00D});
        vecs.push_back('{1'b0, 1'b1, 32'd525312, 32'h0,        99, 32'hDEADBEEF});
        vecs.push_back('{1'b0, 1'b1, 32'd1035,   32'h0,        3,  32'h12345678});

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_we_n", 32'(sram_we_n), 32'd1);
        check("reset_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("reset_sram_addr", 32'(sram_addr), 32'd0);
        check("reset_dq_o", 32'(sram_dq_o), 32'd0);
        check("reset_rd_data", rd_data, 32'd0);

        // Idle with no request: strobes stay off, SRAM sees no writes
        w0 = sram_writes;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("idle_ready", 32'(ready), 32'd1);
            check("idle_strobes", {30'd0, sram_we_n, sram_dq_oe}, 32'h2);
        end
        check("idle_no_writes", sram_writes, w0);
        @(posedge clk);
        #1;

        // Directed vector table, applied back to back
        foreach (vecs[i]) begin
            v = vecs[i];
            xact(v.wr, v.rd, v.addr, v.data, v.drop_at, lat, wl);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd5);
            check($sformatf("vec%0d_we_low", i), 32'(wl), v.wr ? 32'd4 : 32'd0);
            check($sformatf("vec%0d_rd_data", i), rd_data, v.exp_rd);
        end
        check("sram0", 32'(sram[0]), 32'h0000BEEF);
        check("sram1", 32'(sram[1]), 32'h0000DEAD);
        check("sram2", 32'(sram[2]), 32'h0000A5A5);
        check("sram3", 32'(sram[3]), 32'h0000A5A5);
        check("sram4", 32'(sram[4]), 32'h00005678);
        check("sram5", 32'(sram[5]), 32'h00001234);
        check("sram_wrap_lo", 32'(sram[18'h3FFFE]), 32'h0000F00D);
        check("sram_wrap_hi", 32'(sram[18'h3FFFF]), 32'h0000CAFE);

        // Reset while in the high write phase
        wr_en   = 1'b1;
        address = 32'd1040;
        wr_data = 32'h11112222;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c < 3) begin
                @(posedge clk);
                #1;
            end
        end
        rst   = 1'b1;
        wr_en = 1'b0;
        @(posedge clk);
        #1;
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_rd_data", rd_data, 32'd0);
        rst = 1'b0;
        model_apply(1'b1, 1'b0, 32'd1040, 32'h11112222);
        ref_last_rd = 32'h0;
        @(posedge clk);
        #1;
        xact(1'b0, 1'b1, 32'd1040, 32'h0, 99, lat, wl);
        check("rst_readback", rd_data, 32'h11112222);

        // Randomized traffic against the reference model
        for (int i = 0; i < 16; i++) begin
            xact(1'b1, 1'b0, 32'd1024 + 32'(i) * 4, $urandom, 99, lat, wl);
        end
        for (int n = 0; n < 60; n++) begin
            int unsigned op;
            logic [31:0] a;
            int          drop;
            op   = $urandom_range(0, 2);
            a    = 32'd1024 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3))
                   + 32'($urandom_range(0, 3)) * 32'h0008_0000;
            drop = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4)) : 99;
            xact(op != 1, op != 0, a, $urandom, drop, lat, wl);
            check($sformatf("rnd%0d_latency", n), 32'(lat), 32'd5);
            check($sformatf("rnd%0d_we_low", n), 32'(wl), (op != 1) ? 32'd4 : 32'd0);
            check($sformatf("rnd%0d_rd_data", n), rd_data, ref_last_rd);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
